// File: rtl/seeker_lock_ctrl_if.sv
// Seeker-bank / lock-controller bundle. The master side (gearbox + seeker
// bank) drives the window and seeker status; the slave side is the lock
// controller, which returns seeker resets and the published lane lock.
interface seeker_lock_ctrl_if #(
  parameter int N_SEEKERS = 4
);
  logic [66:0]            win_i;
  logic                   win_dv_i;
  logic [N_SEEKERS-1:0]   seek_synced_i;
  logic [7*N_SEEKERS-1:0] seek_offset_i;
  logic [N_SEEKERS-1:0]   seek_rst_o;
  logic                   locked_o;
  logic [6:0]             lock_offset_o;
  logic [2:0]             lock_lane_o;
  logic [7:0]             relock_cnt_o;
  logic                   timeout_o;

  modport master (
    output win_i, win_dv_i, seek_synced_i, seek_offset_i,
    input  seek_rst_o, locked_o, lock_offset_o, lock_lane_o, relock_cnt_o, timeout_o
  );

  modport slave (
    input  win_i, win_dv_i, seek_synced_i, seek_offset_i,
    output seek_rst_o, locked_o, lock_offset_o, lock_lane_o, relock_cnt_o, timeout_o
  );
endinterface

// File: rtl/seeker_lock_ctrl.sv
// Lock-acquisition controller for the 66b header aligner.
// RESTART holds the seekers in reset, SEARCH takes the lowest-index seeker
// that reports sync, LOCKED watches headers at the captured offset and
// restarts after too many bad headers in one window.
// Build option: SEEK_CTRL_PARK_EN holds the seekers in reset while LOCKED.

// Per-seeker offset clamp: anything past the last legal header slot maps to 65.
module seeker_off_clamp (
  input  logic [6:0] off_raw,
  output logic [6:0] off_clamped
);
  assign off_clamped = (off_raw > 7'd65) ? 7'd65 : off_raw;
endmodule

module seeker_lock_ctrl #(
  parameter int N_SEEKERS      = 4,
  parameter int RST_CYC        = 2,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOCK_WIN       = 64,
  parameter int BAD_HDR_MAX    = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  seeker_lock_ctrl_if.slave bus
);
`ifdef SEEK_CTRL_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif
  localparam int RCW = $clog2(RST_CYC + 1);
  localparam int TCW = $clog2(SEARCH_TIMEOUT);
  localparam int FCW = $clog2(LOCK_WIN);
  localparam int BCW = $clog2(BAD_HDR_MAX + 1);

  typedef enum logic [1:0] {ST_RESTART, ST_SEARCH, ST_LOCKED} state_t;

  state_t                 state_q, state_d;
  logic [RCW-1:0]         rst_cnt_q, rst_cnt_d;
  logic [TCW-1:0]         tcnt_q, tcnt_d;
  logic [FCW-1:0]         fcnt_q, fcnt_d;
  logic [BCW-1:0]         bcnt_q, bcnt_d, bcnt_inc;
  logic [N_SEEKERS-1:0]   seek_rst_q, seek_rst_d;
  logic                   locked_q, locked_d;
  logic [6:0]             off_q, off_d;
  logic [2:0]             lane_q, lane_d;
  logic [7:0]             relock_q, relock_d;
  logic                   timeout_q, timeout_d;

  logic [N_SEEKERS-1:0][6:0] off_cl;
  logic                      hit;
  logic [2:0]                hit_lane;
  logic [6:0]                hit_off;
  logic [66:0]               win_sh;
  logic                      bad;

  for (genvar k = 0; k < N_SEEKERS; k++) begin : g_lane
    seeker_off_clamp u_clamp (
      .off_raw    (bus.seek_offset_i[7*k +: 7]),
      .off_clamped(off_cl[k])
    );
  end

  // Lowest-index synced seeker wins; scanning downward lets the lowest overwrite.
  always_comb begin
    hit      = 1'b0;
    hit_lane = '0;
    hit_off  = '0;
    for (int k = N_SEEKERS - 1; k >= 0; k--) begin
      if (bus.seek_synced_i[k]) begin
        hit      = 1'b1;
        hit_lane = 3'(k);
        hit_off  = off_cl[k];
      end
    end
  end

  // Header at the locked offset; only 01/10 are legal sync headers.
  always_comb begin
    win_sh   = bus.win_i >> off_q;
    bad      = ~(win_sh[1] ^ win_sh[0]);
    bcnt_inc = bcnt_q + BCW'(bad);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    tcnt_d    = tcnt_q;
    fcnt_d    = fcnt_q;
    bcnt_d    = bcnt_q;
    locked_d  = locked_q;
    off_d     = off_q;
    lane_d    = lane_q;
    relock_d  = relock_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_RESTART: begin
        rst_cnt_d = rst_cnt_q + 1'b1;
        if (rst_cnt_q == RCW'(RST_CYC - 1)) begin
          state_d = ST_SEARCH;
          tcnt_d  = '0;
          fcnt_d  = '0;
          bcnt_d  = '0;
        end
      end
      ST_SEARCH: begin
        if (hit) begin
          state_d  = ST_LOCKED;
          locked_d = 1'b1;
          off_d    = hit_off;
          lane_d   = hit_lane;
        end else if (bus.win_dv_i) begin
          if (tcnt_q == TCW'(SEARCH_TIMEOUT - 1)) begin
            state_d   = ST_RESTART;
            rst_cnt_d = '0;
            timeout_d = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (bus.win_dv_i) begin
          if (bcnt_inc == BCW'(BAD_HDR_MAX)) begin
            state_d   = ST_RESTART;
            rst_cnt_d = '0;
            locked_d  = 1'b0;
            if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
            bcnt_d = (fcnt_q == FCW'(LOCK_WIN - 1)) ? '0 : bcnt_inc;
          end
        end
      end
      default: state_d = ST_RESTART;
    endcase
    seek_rst_d = ((state_d == ST_RESTART) || (PARK && (state_d == ST_LOCKED))) ? '1 : '0;
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_RESTART;
      rst_cnt_q  <= '0;
      tcnt_q     <= '0;
      fcnt_q     <= '0;
      bcnt_q     <= '0;
      seek_rst_q <= '1;
      locked_q   <= 1'b0;
      off_q      <= '0;
      lane_q     <= '0;
      relock_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      tcnt_q     <= tcnt_d;
      fcnt_q     <= fcnt_d;
      bcnt_q     <= bcnt_d;
      seek_rst_q <= seek_rst_d;
      locked_q   <= locked_d;
      off_q      <= off_d;
      lane_q     <= lane_d;
      relock_q   <= relock_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.seek_rst_o    = seek_rst_q;
  assign bus.locked_o      = locked_q;
  assign bus.lock_offset_o = off_q;
  assign bus.lock_lane_o   = lane_q;
  assign bus.relock_cnt_o  = relock_q;
  assign bus.timeout_o     = timeout_q;
endmodule

// File: tb/tb_seeker_lock_ctrl.sv
// Bench for seeker_lock_ctrl: directed table, hand-written corner sequences
// and a randomized run, all checked against a frame-level reference model.
module tb_seeker_lock_ctrl;
  localparam int N = 4, RST_CYC = 2, TMO = 1024, LW = 64, BMAX = 16;
`ifdef SEEK_CTRL_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif
  localparam logic [N-1:0] ONES = '1;
  localparam logic [N-1:0] PK   = PARK ? ONES : '0;
  localparam int M_RST = 0, M_SRCH = 1, M_LOCK = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seeker_lock_ctrl_if #(.N_SEEKERS(N)) bus();

  seeker_lock_ctrl #(
    .N_SEEKERS(N), .RST_CYC(RST_CYC), .SEARCH_TIMEOUT(TMO),
    .LOCK_WIN(LW), .BAD_HDR_MAX(BMAX)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int vectors = 0, miscompares = 0, cyc = 0;

  // reference model state: what the lane "is doing", in frame terms
  int   m_mode, m_left, m_sframes, m_wframes, m_bad, m_off, m_lane, m_relock;
  logic m_locked, m_tmo;

  typedef struct {
    logic           rst_n;
    logic [N-1:0]   sync;
    logic [7*N-1:0] offs;
    logic           dv;
    int             hoff;
    logic [1:0]     hdr;
    logic [N-1:0]   e_rst;
    logic           e_lock;
    logic [6:0]     e_off;
    logic [2:0]     e_lane;
  } vec_t;
  vec_t tbl[14];

  function automatic vec_t mkv(logic r, logic [N-1:0] s, logic [7*N-1:0] o, logic d,
                               int ho, logic [1:0] h, logic [N-1:0] er, logic el,
                               logic [6:0] eo, logic [2:0] ela);
    vec_t v;
    v.rst_n = r; v.sync = s; v.offs = o; v.dv = d; v.hoff = ho; v.hdr = h;
    v.e_rst = er; v.e_lock = el; v.e_off = eo; v.e_lane = ela;
    return v;
  endfunction

  function automatic logic [7*N-1:0] po(int k, int v);
    logic [7*N-1:0] t;
    t = '0;
    t[7*k +: 7] = 7'(v);
    return t;
  endfunction

  function automatic logic [66:0] make_win(int off, logic [1:0] hdr);
    logic [95:0] r;
    logic [66:0] w;
    r = {$urandom, $urandom, $urandom};
    w = r[66:0];
    w[off]   = hdr[0];
    w[off+1] = hdr[1];
    return w;
  endfunction

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  task automatic model_reset();
    m_mode = M_RST; m_left = RST_CYC; m_sframes = 0; m_wframes = 0; m_bad = 0;
    m_off = 0; m_lane = 0; m_relock = 0; m_locked = 1'b0; m_tmo = 1'b0;
  endtask

  task automatic enter_restart();
    m_mode = M_RST;
    m_left = RST_CYC;
  endtask

  // one clock edge worth of lane behaviour, from the current inputs
  task automatic model_edge();
    int k, raw;
    logic [66:0] sh;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_tmo = 1'b0;
    case (m_mode)
      M_RST: begin
        m_left--;
        if (m_left == 0) begin
          m_mode = M_SRCH;
          m_sframes = 0;
        end
      end
      M_SRCH: begin
        if (|bus.seek_synced_i) begin
          k = 0;
          while (!bus.seek_synced_i[k]) k++;
          raw = int'(bus.seek_offset_i[7*k +: 7]);
          m_off = (raw > 65) ? 65 : raw;
          m_lane = k;
          m_locked = 1'b1;
          m_mode = M_LOCK;
          m_wframes = 0;
          m_bad = 0;
        end else if (bus.win_dv_i) begin
          m_sframes++;
          if (m_sframes == TMO) begin
            m_tmo = 1'b1;
            enter_restart();
          end
        end
      end
      default: begin
        if (bus.win_dv_i) begin
          sh = bus.win_i >> m_off;
          if (sh[1] == sh[0]) m_bad++;
          m_wframes++;
          if (m_bad >= BMAX) begin
            m_locked = 1'b0;
            if (m_relock < 255) m_relock++;
            enter_restart();
          end else if (m_wframes == LW) begin
            m_wframes = 0;
            m_bad = 0;
          end
        end
      end
    endcase
  endtask

  task automatic check_model(string tag);
    logic [N-1:0] e_seek;
    bit bad;
    e_seek = (m_mode == M_RST) ? ONES : ((m_mode == M_LOCK) ? PK : '0);
    bad = 0;
    if (bus.seek_rst_o !== e_seek) begin
      bad = 1; $display("FAIL %s cyc=%0d seek_rst got %h want %h", tag, cyc, bus.seek_rst_o, e_seek);
    end
    if (bus.locked_o !== m_locked) begin
      bad = 1; $display("FAIL %s cyc=%0d locked got %b want %b", tag, cyc, bus.locked_o, m_locked);
    end
    if (int'(bus.lock_offset_o) != m_off || $isunknown(bus.lock_offset_o)) begin
      bad = 1; $display("FAIL %s cyc=%0d lock_offset got %0d want %0d", tag, cyc, bus.lock_offset_o, m_off);
    end
    if (int'(bus.lock_lane_o) != m_lane || $isunknown(bus.lock_lane_o)) begin
      bad = 1; $display("FAIL %s cyc=%0d lock_lane got %0d want %0d", tag, cyc, bus.lock_lane_o, m_lane);
    end
    if (int'(bus.relock_cnt_o) != m_relock || $isunknown(bus.relock_cnt_o)) begin
      bad = 1; $display("FAIL %s cyc=%0d relock_cnt got %0d want %0d", tag, cyc, bus.relock_cnt_o, m_relock);
    end
    if (bus.timeout_o !== m_tmo) begin
      bad = 1; $display("FAIL %s cyc=%0d timeout got %b want %b", tag, cyc, bus.timeout_o, m_tmo);
    end
    vectors++;
    if (bad) miscompares++;
  endtask

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(string tag);
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_model(tag);
  endtask

  task automatic idle_in();
    bus.seek_synced_i = '0;
    bus.seek_offset_i = '0;
    bus.win_dv_i = 1'b0;
    bus.win_i = '0;
  endtask

  task automatic go_reset();
    idle_in();
    rst_n = 1'b0;
    step("rst");
    rst_n = 1'b1;
    step("rst");
    step("rst");
  endtask

  task automatic lock_at(int off);
    bus.seek_synced_i = 4'b0001;
    bus.seek_offset_i = po(0, off);
    bus.win_dv_i = 1'b0;
    step("lock");
    bus.seek_synced_i = '0;
  endtask

  task automatic frame(int off, logic [1:0] hdr);
    bus.win_dv_i = 1'b1;
    bus.win_i = make_win(off, hdr);
    step("frame");
    bus.win_dv_i = 1'b0;
  endtask

  initial begin
    model_reset();
    idle_in();

    // directed table: first lock, sync ignored while locked, priority, clamp
    tbl[0]  = mkv(0, 4'b0000, '0,                  0, 0,  2'b00, ONES, 0, 0,  0);
    tbl[1]  = mkv(1, 4'b0000, '0,                  0, 0,  2'b00, ONES, 0, 0,  0);
    tbl[2]  = mkv(1, 4'b0000, '0,                  0, 0,  2'b00, '0,   0, 0,  0);
    tbl[3]  = mkv(1, 4'b0100, po(2,37)|po(0,3),    0, 0,  2'b00, PK,   1, 37, 2);
    tbl[4]  = mkv(1, 4'b0001, po(0,9),             1, 37, 2'b01, PK,   1, 37, 2);
    tbl[5]  = mkv(0, 4'b0000, '0,                  0, 0,  2'b00, ONES, 0, 0,  0);
    tbl[6]  = mkv(1, 4'b0000, '0,                  0, 0,  2'b00, ONES, 0, 0,  0);
    tbl[7]  = mkv(1, 4'b0000, '0,                  0, 0,  2'b00, '0,   0, 0,  0);
    tbl[8]  = mkv(1, 4'b1010, po(1,5)|po(3,11),    0, 0,  2'b00, PK,   1, 5,  1);
    tbl[9]  = mkv(0, 4'b0000, '0,                  0, 0,  2'b00, ONES, 0, 0,  0);
    tbl[10] = mkv(1, 4'b0000, '0,                  0, 0,  2'b00, ONES, 0, 0,  0);
    tbl[11] = mkv(1, 4'b0000, '0,                  0, 0,  2'b00, '0,   0, 0,  0);
    tbl[12] = mkv(1, 4'b0001, po(0,100),           0, 0,  2'b00, PK,   1, 65, 0);
    tbl[13] = mkv(1, 4'b0000, '0,                  1, 65, 2'b10, PK,   1, 65, 0);
    for (int i = 0; i < 14; i++) begin
      rst_n = tbl[i].rst_n;
      bus.seek_synced_i = tbl[i].sync;
      bus.seek_offset_i = tbl[i].offs;
      bus.win_dv_i = tbl[i].dv;
      bus.win_i = make_win(tbl[i].hoff, tbl[i].hdr);
      step("tbl");
      chk($sformatf("tbl%0d_seek_rst", i), int'(bus.seek_rst_o), int'(tbl[i].e_rst));
      chk($sformatf("tbl%0d_locked", i), int'(bus.locked_o), int'(tbl[i].e_lock));
      chk($sformatf("tbl%0d_offset", i), int'(bus.lock_offset_o), int'(tbl[i].e_off));
      chk($sformatf("tbl%0d_lane", i), int'(bus.lock_lane_o), int'(tbl[i].e_lane));
    end

    // search timeout, with a long idle gap that must freeze the counter
    begin
      int tmo_seen;
      go_reset();
      tmo_seen = 0;
      bus.win_dv_i = 1'b1;
      for (int i = 0; i < 1000; i++) begin
        bus.win_i = make_win(0, 2'b01);
        step("tmo_a");
        tmo_seen += int'(bus.timeout_o);
      end
      bus.win_dv_i = 1'b0;
      for (int i = 0; i < 5000; i++) begin
        step("tmo_idle");
        tmo_seen += int'(bus.timeout_o) + int'(bus.seek_rst_o != '0);
      end
      chk("tmo_idle_quiet", tmo_seen, 0);
      bus.win_dv_i = 1'b1;
      for (int i = 0; i < 23; i++) step("tmo_b");
      chk("tmo_1023_frames", int'(bus.timeout_o), 0);
      step("tmo_hit");
      chk("tmo_pulse", int'(bus.timeout_o), 1);
      chk("tmo_seek_rst0", int'(bus.seek_rst_o), int'(ONES));
      bus.win_dv_i = 1'b0;
      step("tmo_r1");
      chk("tmo_pulse_end", int'(bus.timeout_o), 0);
      chk("tmo_seek_rst1", int'(bus.seek_rst_o), int'(ONES));
      step("tmo_r2");
      chk("tmo_seek_rst_done", int'(bus.seek_rst_o), 0);
    end

    // loss of lock: 16 bad headers inside one window
    go_reset();
    lock_at(10);
    for (int i = 0; i < 10; i++) frame(10, good_hdr());
    for (int i = 0; i < 15; i++) begin
      frame(10, (i % 2) ? 2'b00 : 2'b11);
      frame(10, good_hdr());
    end
    chk("loss_15_held", int'(bus.locked_o), 1);
    frame(10, 2'b00);
    chk("loss_locked", int'(bus.locked_o), 0);
    chk("loss_relock", int'(bus.relock_cnt_o), 1);
    chk("loss_seek_rst", int'(bus.seek_rst_o), int'(ONES));

    // window reset: 15+15 bad across two windows holds, then 16th on frame 63
    go_reset();
    lock_at(20);
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < LW; i++) frame(20, (i < 15) ? 2'b00 : good_hdr());
    chk("win_held", int'(bus.locked_o), 1);
    chk("win_relock0", int'(bus.relock_cnt_o), 0);
    for (int i = 0; i < LW - 1; i++) frame(20, (i >= 48) ? bad_hdr() : good_hdr());
    chk("win_62_held", int'(bus.locked_o), 1);
    frame(20, 2'b00);
    chk("win_63_loss", int'(bus.locked_o), 0);
    chk("win_63_relock", int'(bus.relock_cnt_o), 1);

    // async reset mid-lock with three relocks on the counter
    go_reset();
    for (int n = 0; n < 3; n++) begin
      lock_at(7);
      for (int i = 0; i < BMAX; i++) frame(7, 2'b11);
      step("ar_r");
      step("ar_r");
    end
    chk("ar_relock3", int'(bus.relock_cnt_o), 3);
    lock_at(7);
    chk("ar_locked", int'(bus.locked_o), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar_locked0", int'(bus.locked_o), 0);
    chk("ar_relock0", int'(bus.relock_cnt_o), 0);
    chk("ar_seek_rst", int'(bus.seek_rst_o), int'(ONES));
    chk("ar_offset0", int'(bus.lock_offset_o), 0);
    chk("ar_lane0", int'(bus.lock_lane_o), 0);
    chk("ar_timeout0", int'(bus.timeout_o), 0);
    step("ar_hold");
    rst_n = 1'b1;

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
      bus.seek_synced_i = ($urandom_range(0, 29) == 0) ? N'($urandom) : '0;
      bus.seek_offset_i = (7*N)'($urandom);
      bus.win_dv_i = ($urandom_range(0, 3) != 0);
      if (m_mode == M_LOCK)
        bus.win_i = make_win(m_off, ($urandom_range(0, 3) == 0) ? bad_hdr() : good_hdr());
      else
        bus.win_i = make_win(int'($urandom_range(0, 65)), 2'($urandom));
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seeker_lock_ctrl.md
# seeker_lock_ctrl

Lock-acquisition controller for the Aurora-style 66b header aligner. It sequences a bank of `N_SEEKERS` header seekers, each searching an interleaved set of offsets in the 67-bit gearbox window. It selects the first seeker to report sync and publishes that offset as the lane lock. It then monitors headers at the locked offset and restarts the search on loss of lock or search timeout. It sits between the gearbox/seeker bank and the frame descrambler.

## Interface
- `N_SEEKERS`, 4, number of seekers controlled (1..8)
- `RST_CYC`, 2, cycles `seek_rst_o` is held during a restart (≥1)
- `SEARCH_TIMEOUT`, 1024, valid frames allowed in SEARCH before restart (≥2)
- `LOCK_WIN`, 64, frames per loss-of-lock evaluation window (power of 2, ≥4)
- `BAD_HDR_MAX`, 16, invalid headers within one window that force relock (1..`LOCK_WIN`)

Ports:
- `clk_i`  in  1  system clock
- `rst_ni`  in  1  asynchronous active-low reset
- `win_i`  in  67  gearbox window; same slice the seekers register
- `win_dv_i`  in  1  `win_i` valid, one frame per pulse
- `seek_synced_i`  in  N_SEEKERS  per-seeker sync flag
- `seek_offset_i`  in  7*N_SEEKERS  per-seeker offset; seeker k at bits [7k+6:7k]
- `seek_rst_o`  out  N_SEEKERS  active-high synchronous reset to the seekers
- `locked_o`  out  1  lane lock valid
- `lock_offset_o`  out  7  locked header offset (0..65)
- `lock_lane_o`  out  3  index of the winning seeker
- `relock_cnt_o`  out  8  saturating count of loss-of-lock events
- `timeout_o`  out  1  one-cycle pulse on search timeout

## Operation
- States: RESTART, SEARCH, LOCKED.
- **RESET state:** async reset asserted → RESTART with `rst_cnt`=0.
  - Outputs during reset: `seek_rst_o` all ones; `locked_o`=0; `lock_offset_o`=0; `lock_lane_o`=0; `relock_cnt_o`=0; `timeout_o`=0.
- **RESTART:**
  - `seek_rst_o` is all ones.
  - `rst_cnt` increments every cycle, independent of `win_dv_i`.
  - After `RST_CYC` cycles → SEARCH, with timeout, frame and bad-header counters cleared.
- **SEARCH:**
  - `seek_rst_o` is 0.
  - The timeout counter increments on each `win_dv_i`.
  - If any `seek_synced_i` bit is set: the lowest set index k wins.
    - Capture `lock_lane_o`=k and `lock_offset_o`=offset k.
    - Set `locked_o`=1 and go to LOCKED.
  - Else, when the counter reaches `SEARCH_TIMEOUT`-1 on a valid frame: pulse `timeout_o` and go to RESTART.
  - Sync and timeout in the same cycle: sync wins.
- **LOCKED:**
  - Each valid frame evaluates `hdr = win_i[lock_offset_o+1 -: 2]`. A header is bad unless it is 2'b01 or 2'b10.
  - The frame counter counts valid frames modulo `LOCK_WIN`. The bad counter increments on bad headers.
  - Loss of lock: the bad count including the current frame reaches `BAD_HDR_MAX`.
    - Clear `locked_o`.
    - Increment `relock_cnt_o`, saturating at 255.
    - Go to RESTART.
  - Otherwise, on the last frame of a window, clear the bad counter.
  - Threshold reached on the window's last frame: relock wins.
  - `seek_synced_i` is ignored in LOCKED; a seeker dropping sync does not affect lock.
- `lock_offset_o` and `lock_lane_o` hold their last values outside LOCKED.
- Offsets above 65 from a seeker are clamped to 65 on capture.

## Timing
- All outputs are registered. Combinational inputs-to-outputs paths are forbidden.
- Lock latency: `locked_o` rises on the edge after the cycle in which `seek_synced_i` is seen high in SEARCH.
- Loss latency: `locked_o` falls and `seek_rst_o` rises on the edge after the offending frame.
- Restart length: `seek_rst_o` is high for exactly `RST_CYC` cycles, except in the feature-enabled LOCKED case below.
- `timeout_o` is high for exactly one cycle, coincident with the first RESTART cycle.
- `win_dv_i` low freezes the search and lock counters. The RESTART counter keeps running.
- Async reset mid-lock: all outputs go to reset values immediately. `relock_cnt_o` is not preserved.

## Configuration
- `SEEK_CTRL_PARK_EN`
  - Defined: in LOCKED, `seek_rst_o` is all ones, parking the seekers to save power. Seekers then start cold after loss of lock.
  - Undefined: `seek_rst_o`=0 in LOCKED and seekers keep running.
- The state machine, lock latency and relock behaviour are identical in both builds.

## Test plan
- **Reset and first lock:** release reset; after 2 cycles `seek_rst_o`=0. Seeker 2 raises sync with offset 37 → next edge `locked_o`=1, `lock_offset_o`=37, `lock_lane_o`=2.
- **Priority:** seekers 1 and 3 sync in the same cycle with offsets 5 and 11 → `lock_lane_o`=1, `lock_offset_o`=5.
- **Timeout:** no sync for 1024 valid frames → `timeout_o` one-cycle pulse and `seek_rst_o` high for 2 cycles. No timeout when `win_dv_i` is held low for 5000 cycles.
- **Loss of lock:** locked at offset 10; inject 16 headers of 2'b00 within 64 frames → `locked_o`=0, `relock_cnt_o`=1, RESTART.
- **Window reset:** 15 bad headers in window 1, then 15 in window 2 → lock held and `relock_cnt_o`=0. 16th bad header on frame 63 of a window → relock.
- **Async reset mid-lock:** with `relock_cnt_o`=3, pull `rst_ni` low → outputs reset immediately. Build with `SEEK_CTRL_PARK_EN` → `seek_rst_o`=all ones throughout LOCKED.
